buy_request_queue: RTL and testbench

Sits between the PS/2 keyboard decoder and the vending-machine core. Turns raw keyboard make/break events into clean, one-per-press purchase requests, encoded one-hot to match the vending machine's 4-bit `buy` input. A small FIFO buffers requests, so presses made while the vending core is busy (e.g. returning change) are held and replayed once it accepts them.

---
 rtl/vending_pkg.sv | 23 ++
 rtl/buy_request_queue_if.sv | 30 +++
 rtl/buy_fifo.sv | 53 +++++
 rtl/buy_request_queue.sv | 115 +++++++++++
 tb/tb_buy_request_queue.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vending_pkg.sv
// Shared key-code constants, item index type and one-hot helper for the vending front end.
// Latency: none (declarations only).
// Backpressure: not applicable.
package vending_pkg;

    // Nine-bit codes are {extend, scan_code}; every mapped key has extend=0.
    localparam logic [8:0] KEY_CODES_A   = 9'h01C;
    localparam logic [8:0] KEY_CODES_S   = 9'h01B;
    localparam logic [8:0] KEY_CODES_D   = 9'h023;
    localparam logic [8:0] KEY_CODES_F   = 9'h02B;
    localparam logic [8:0] KEY_CODES_KP1 = 9'h069;
    localparam logic [8:0] KEY_CODES_KP2 = 9'h072;
    localparam logic [8:0] KEY_CODES_KP3 = 9'h07A;
    localparam logic [8:0] KEY_CODES_KP4 = 9'h06B;

    // Item index: 3 = A (buy[3]) down to 0 = F (buy[0]).
    typedef logic [1:0] item_t;

    function automatic logic [3:0] item_onehot(input item_t idx);
        item_onehot = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/buy_request_queue_if.sv
// Keyboard-event input and purchase-request output bundle of the buy request queue.
// Latency: none (wiring only).
// Backpressure: buy_valid/buy_ready handshake on the request side; key events cannot be stalled.
interface buy_request_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          key_valid;
    logic [8:0]    key_code;
    logic          key_break;
    logic          buy_ready;
    logic          flush;
    logic          buy_valid;
    logic [3:0]    buy;
    logic [3:0]    held;
    logic [CW-1:0] count;
    logic [7:0]    drop_cnt;

    modport master (
        output key_valid, key_code, key_break, buy_ready, flush,
        input  buy_valid, buy, held, count, drop_cnt
    );

    modport slave (
        input  key_valid, key_code, key_break, buy_ready, flush,
        output buy_valid, buy, held, count, drop_cnt
    );

endinterface

// File: rtl/buy_fifo.sv
// DEPTH x 2-bit synchronous FIFO of item indices with flush and occupancy count.
// Latency: a push is visible at the head one cycle later; head is read straight from storage.
// Backpressure: push accepted when not full or when popping the same cycle; flush overrides both.
module buy_fifo
    import vending_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  item_t                  push_dat,
    input  logic                   pop,
    input  logic                   flush,
    output item_t                  head_dat,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    item_t          mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW + 1)'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign head_dat = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two; flush simply re-zeroes them.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // Entry storage carries no reset; stale contents are masked by the count.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/buy_request_queue.sv
// Turns keyboard make/break events into one-per-press one-hot buy requests, buffered in a FIFO.
// Latency: press to head 1 cycle when empty; otherwise queued behind earlier requests.
// Backpressure: buy_ready stalls the head; presses arriving while full (no pop) are dropped and counted.
// Build option BUY_NUMPAD_EN adds numpad keys KP1..KP4 with their own held bits.
module buy_request_queue
    import vending_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    buy_request_queue_if.slave     bus
);
    logic        press;
    logic        letter_hit;
    item_t       letter_idx;
    logic        letter_push;
    logic [3:0]  held_l;
    logic        push_req;
    item_t       push_item;
    logic [3:0]  held_all;
    logic        pop_fire;
    logic        drop;
    item_t       head_dat;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  drop_cnt;

    assign press = bus.key_valid && !bus.key_break;

    // Letter key map; the extend bit is part of the code so extended codes never match.
    always_comb begin
        letter_hit = 1'b1;
        letter_idx = 2'd0;
        case (bus.key_code)
            KEY_CODES_A: letter_idx = 2'd3;
            KEY_CODES_S: letter_idx = 2'd2;
            KEY_CODES_D: letter_idx = 2'd1;
            KEY_CODES_F: letter_idx = 2'd0;
            default:     letter_hit = 1'b0;
        endcase
    end

    assign letter_push = press && letter_hit && !held_l[letter_idx];

    // Letter held bits: set on press, cleared on release, so typematic repeats are ignored.
    always_ff @(posedge clk) begin
        if (rst)                              held_l <= '0;
        else if (bus.key_valid && letter_hit) held_l[letter_idx] <= !bus.key_break;
    end

`ifdef BUY_NUMPAD_EN
    logic        kp_hit;
    item_t       kp_idx;
    logic        kp_push;
    logic [3:0]  held_k;

    // Numpad key map, same item order as the letters.
    always_comb begin
        kp_hit = 1'b1;
        kp_idx = 2'd0;
        case (bus.key_code)
            KEY_CODES_KP1: kp_idx = 2'd3;
            KEY_CODES_KP2: kp_idx = 2'd2;
            KEY_CODES_KP3: kp_idx = 2'd1;
            KEY_CODES_KP4: kp_idx = 2'd0;
            default:       kp_hit = 1'b0;
        endcase
    end

    assign kp_push = press && kp_hit && !held_k[kp_idx];

    // Numpad held bits are independent of the letter ones so either key can trigger a push.
    always_ff @(posedge clk) begin
        if (rst)                          held_k <= '0;
        else if (bus.key_valid && kp_hit) held_k[kp_idx] <= !bus.key_break;
    end

    assign push_req  = letter_push || kp_push;
    assign push_item = letter_hit ? letter_idx : kp_idx;
    assign held_all  = held_l | held_k;
`else
    assign push_req  = letter_push;
    assign push_item = letter_idx;
    assign held_all  = held_l;
`endif

    assign pop_fire = !fifo_empty && bus.buy_ready;
    assign drop     = push_req && fifo_full && !pop_fire && !bus.flush;

    buy_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_req),
        .push_dat (push_item),
        .pop      (pop_fire),
        .flush    (bus.flush),
        .head_dat (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (bus.count)
    );

    // Saturating count of presses lost to a full FIFO; flush neither clears nor feeds it.
    always_ff @(posedge clk) begin
        if (rst)                          drop_cnt <= '0;
        else if (drop && drop_cnt != '1)  drop_cnt <= drop_cnt + 1'b1;
    end

    assign bus.buy_valid = !fifo_empty;
    assign bus.buy       = fifo_empty ? 4'b0000 : item_onehot(head_dat);
    assign bus.held      = held_all;
    assign bus.drop_cnt  = drop_cnt;

endmodule

// File: tb/tb_buy_request_queue.sv
// Randomised and directed stimulus against a queue-based reference model with a decoupled monitor.
// Latency: checks DUT state every cycle on the falling edge.
// Backpressure: buy_ready driven in random low/high phases to exercise full and drain behaviour.
module tb_buy_request_queue;
    localparam int DEPTH = 4;
    localparam logic [8:0] C_A = 9'h01C;
    localparam logic [8:0] C_S = 9'h01B;
    localparam logic [8:0] C_D = 9'h023;
    localparam logic [8:0] C_F = 9'h02B;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    buy_request_queue_if #(.DEPTH(DEPTH)) bus();

    buy_request_queue #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   checks = 0;
    int   errors = 0;
    int   exp_q[$];
    bit   held_l[4];
    bit   held_k[4];
    int   exp_drop;
    bit   popped;
    bit   mon_en = 1'b0;
    logic [3:0] mon_eb;
    logic [3:0] mon_held;
    int   mon_tmp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Item index for a 9-bit code (A=3 .. F=0), or -1 when the code is not mapped.
    function automatic int lookup(input logic [8:0] c, output bit kp);
        kp = 1'b0;
        case (c)
            9'h01C: return 3;
            9'h01B: return 2;
            9'h023: return 1;
            9'h02B: return 0;
`ifdef BUY_NUMPAD_EN
            9'h069: begin kp = 1'b1; return 3; end
            9'h072: begin kp = 1'b1; return 2; end
            9'h07A: begin kp = 1'b1; return 1; end
            9'h06B: begin kp = 1'b1; return 0; end
`endif
            default: return -1;
        endcase
    endfunction

    // Advance the reference model by one clock using the inputs currently driven.
    task automatic model_update();
        int idx;
        bit kp;
        int sz;
        bit push_req;
        sz       = exp_q.size() + int'(popped);
        push_req = 1'b0;
        idx      = -1;
        if (rst) begin
            exp_q.delete();
            for (int i = 0; i < 4; i++) begin
                held_l[i] = 1'b0;
                held_k[i] = 1'b0;
            end
            exp_drop = 0;
            popped   = 1'b0;
            return;
        end
        if (bus.key_valid) begin
            idx = lookup(bus.key_code, kp);
            if (idx >= 0) begin
                if (bus.key_break) begin
                    if (kp) held_k[idx] = 1'b0;
                    else    held_l[idx] = 1'b0;
                end else if (kp ? !held_k[idx] : !held_l[idx]) begin
                    push_req = 1'b1;
                    if (kp) held_k[idx] = 1'b1;
                    else    held_l[idx] = 1'b1;
                end
            end
        end
        if (bus.flush) exp_q.delete();
        else if (push_req) begin
            if (sz < DEPTH || popped) exp_q.push_back(idx);
            else if (exp_drop < 255)  exp_drop++;
        end
        popped = 1'b0;
    endtask

    // One clock of stimulus: drive just after the rising edge, update the model after the monitor.
    task automatic cycle(input logic r, input logic kv, input logic [8:0] code,
                         input logic brk, input logic rdy, input logic fl);
        @(posedge clk);
        #1;
        rst           = r;
        bus.key_valid = kv;
        bus.key_code  = code;
        bus.key_break = brk;
        bus.buy_ready = rdy;
        bus.flush     = fl;
        @(negedge clk);
        #1;
        model_update();
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic press(input logic [8:0] code, input logic rdy);
        cycle(1'b0, 1'b1, code, 1'b0, rdy, 1'b0);
    endtask

    task automatic release_key(input logic [8:0] code);
        cycle(1'b0, 1'b1, code, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic release_all();
        release_key(C_A);
        release_key(C_S);
        release_key(C_D);
        release_key(C_F);
    endtask

    // Monitor: compare outputs with the model, and retire the expected head on a handshake.
    always @(negedge clk) begin
        if (mon_en) begin
            mon_eb = (exp_q.size() > 0) ? (4'b0001 << exp_q[0]) : 4'b0000;
            mon_held = 4'b0000;
            for (int i = 0; i < 4; i++) mon_held[i] = held_l[i] | held_k[i];
            check("buy_valid", 32'(bus.buy_valid), 32'(exp_q.size() > 0));
            check("buy",       32'(bus.buy),       32'(mon_eb));
            check("count",     32'(bus.count),     32'(exp_q.size()));
            check("held",      32'(bus.held),      32'(mon_held));
            check("drop_cnt",  32'(bus.drop_cnt),  32'(exp_drop));
            if (!rst && bus.buy_ready && exp_q.size() > 0) begin
                mon_tmp = exp_q.pop_front();
                popped  = 1'b1;
            end
        end
    end

    logic [8:0] codes [10] = '{9'h01C, 9'h01B, 9'h023, 9'h02B, 9'h069,
                               9'h072, 9'h07A, 9'h06B, 9'h029, 9'h11C};

    initial begin
        int  rdy_pct;
        logic r_kv;
        logic r_brk;
        logic r_rdy;
        logic r_fl;
        logic r_rst;

        rst           = 1'b1;
        bus.key_valid = 1'b0;
        bus.key_code  = 9'h000;
        bus.key_break = 1'b0;
        bus.buy_ready = 1'b0;
        bus.flush     = 1'b0;
        exp_drop      = 0;
        popped        = 1'b0;

        cycle(1'b1, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0);
        mon_en = 1'b1;
        cycle(1'b1, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0);
        idle();
        check("rst_valid", 32'(bus.buy_valid), 32'd0);
        check("rst_buy",   32'(bus.buy),       32'd0);
        check("rst_count", 32'(bus.count),     32'd0);
        check("rst_held",  32'(bus.held),      32'd0);
        check("rst_drop",  32'(bus.drop_cnt),  32'd0);

        // S press appears one cycle later, then a single pop empties the queue.
        press(C_S, 1'b0);
        cycle(1'b0, 1'b0, 9'h000, 1'b0, 1'b1, 1'b0);
        check("s_valid", 32'(bus.buy_valid), 32'd1);
        check("s_buy",   32'(bus.buy),       32'h4);
        idle();
        check("s_pop_valid", 32'(bus.buy_valid), 32'd0);
        check("s_pop_count", 32'(bus.count),     32'd0);

        // Typematic repeats collapse to one entry; release and re-press adds another.
        press(C_A, 1'b0);
        for (int i = 0; i < 5; i++) press(C_A, 1'b0);
        idle();
        check("rep_count", 32'(bus.count), 32'd1);
        release_key(C_A);
        press(C_A, 1'b0);
        idle();
        check("rep_count2", 32'(bus.count), 32'd2);
        cycle(1'b0, 1'b0, 9'h000, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 9'h000, 1'b0, 1'b1, 1'b0);
        idle();
        release_all();

        // Fill to DEPTH, then one extra press is dropped.
        press(C_D, 1'b0);
        press(C_F, 1'b0);
        press(C_A, 1'b0);
        press(C_S, 1'b0);
        release_key(C_D);
        press(C_D, 1'b0);
        idle();
        check("full_count", 32'(bus.count),    32'd4);
        check("full_drop",  32'(bus.drop_cnt), 32'd1);
        check("full_head",  32'(bus.buy),      32'h2);

        // Press coincident with a pop on a full FIFO is accepted.
        release_key(C_F);
        press(C_F, 1'b1);
        idle();
        check("pp_count", 32'(bus.count),    32'd4);
        check("pp_drop",  32'(bus.drop_cnt), 32'd1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 9'h000, 1'b0, 1'b1, 1'b0);
        idle();
        check("drain_count", 32'(bus.count), 32'd0);
        release_all();

        // Flush with a coincident F press: queue empties, held still tracks F.
        press(C_A, 1'b0);
        press(C_S, 1'b0);
        cycle(1'b0, 1'b1, C_F, 1'b0, 1'b0, 1'b1);
        idle();
        check("fl_count", 32'(bus.count),    32'd0);
        check("fl_buy",   32'(bus.buy),      32'd0);
        check("fl_held0", 32'(bus.held[0]),  32'd1);
        check("fl_drop",  32'(bus.drop_cnt), 32'd1);
        release_all();

        // Extended and unmapped codes are ignored.
        press(9'h11C, 1'b0);
        press(9'h029, 1'b0);
        idle();
        check("ign_count", 32'(bus.count), 32'd0);
        check("ign_held",  32'(bus.held),  32'd0);
`ifdef BUY_NUMPAD_EN
        press(9'h069, 1'b0);
        idle();
        check("kp1_buy", 32'(bus.buy), 32'h8);
        cycle(1'b0, 1'b0, 9'h000, 1'b0, 1'b1, 1'b0);
        release_key(9'h069);
`endif

        // Randomised traffic with alternating backpressure phases.
        rdy_pct = 50;
        for (int n = 0; n < 3000; n++) begin
            if (n % 64 == 0) rdy_pct = ($urandom_range(0, 1) == 0) ? 15 : 80;
            r_kv  = ($urandom_range(0, 99) < 55);
            r_brk = ($urandom_range(0, 99) < 40);
            r_rdy = ($urandom_range(0, 99) < rdy_pct);
            r_fl  = ($urandom_range(0, 99) < 2);
            r_rst = ($urandom_range(0, 999) == 0);
            cycle(r_rst, r_kv, codes[$urandom_range(0, 9)], r_brk, r_rdy, r_fl);
        end

        // Drop counter saturates at 255.
        cycle(1'b1, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 264; i++) begin
            press(C_D, 1'b0);
            release_key(C_D);
        end
        idle();
        check("sat_drop",  32'(bus.drop_cnt), 32'd255);
        check("sat_count", 32'(bus.count),    32'd4);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
